// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// Provides the FSM state enum and the bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // One serial bit lasts two half-bit periods.
    function automatic int unsigned bit_period(input int unsigned half_bit);
        return 2 * half_bit;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO: storage array, wrapping pointers, count, registered full.
// Ports: clk, rstn, push, pop, wdata, rdata, count, full, empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // full is registered from the next count so tx_ready has no path from pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW + 1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO; 5-9 data bits, 1-2 stop bits, optional parity.
// Ports: clk, rstn, sdata/tx_valid/tx_ready push side, tx_busy, fifo_count, txd.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16,
    parameter int PARITY_ODD       = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_BITS-1:0]          sdata,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          txd
);

    localparam int BP = bit_period(CLK_PER_HALF_BIT);
    localparam int CW = (BP > 2) ? $clog2(BP) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_e       state;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rdata;
    logic                 full;
    logic                 empty;
    logic                 bit_end;
    logic                 stop_done;
    logic                 pop;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_valid),
        .pop   (pop),
        .wdata (sdata),
        .rdata (rdata),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign tx_ready  = ~full;
    assign tx_busy   = (state != IDLE) | ~empty;
    assign bit_end   = (cnt == CW'(BP - 1));
    assign stop_done = (state == STOP) & bit_end & (idx == 4'(STOP_BITS - 1));
    // Head leaves the FIFO on the edge a frame starts, from idle or back-to-back.
    assign pop       = ~empty & ((state == IDLE) | stop_done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        shreg <= rdata;
`ifdef UART_TX_PARITY_EN
                        par   <= (^rdata) ^ 1'(PARITY_ODD);
`endif
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd   <= shreg[0];
                        shreg <= shreg >> 1;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= par;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            idx   <= '0;
                            state <= STOP;
`endif
                        end else begin
                            txd   <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        idx   <= '0;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (idx == 4'(STOP_BITS - 1)) begin
                            if (pop) begin
                                shreg <= rdata;
`ifdef UART_TX_PARITY_EN
                                par   <= (^rdata) ^ 1'(PARITY_ODD);
`endif
                                txd   <= 1'b0;
                                state <= START;
                            end else begin
                                txd   <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, corner sequences,
// and randomized traffic against a queue-based line model.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int DB = 7;
    localparam int SB = 2;
    localparam int PO = 1;
    localparam int PB = 1;
`else
    localparam int DB = 8;
    localparam int SB = 1;
    localparam int PO = 0;
    localparam int PB = 0;
`endif
    localparam int HALF  = 4;
    localparam int BP    = 2 * HALF;
    localparam int DEPTH = 4;
    localparam int NBITS = 1 + DB + PB + SB;
    localparam int FLC   = NBITS * BP;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            tx_valid = 1'b0;
    logic [DB-1:0]   sdata = '0;
    logic            tx_ready;
    logic            tx_busy;
    logic            txd;
    logic [CNTW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_PER_HALF_BIT (HALF),
        .DATA_BITS        (DB),
        .STOP_BITS        (SB),
        .FIFO_DEPTH       (DEPTH),
        .PARITY_ODD       (PO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sdata      (sdata),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .txd        (txd)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: queue of accepted characters and remaining cycles of the
    // frame on the wire; frame bits are built from the framing rules.
    logic [DB-1:0] mq[$];
    int            m_left = 0;
    logic [15:0]   m_bits = '1;

    function automatic logic [15:0] frame_of(input logic [DB-1:0] d);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1 + i] = d[i];
        if (PB == 1) f[1 + DB] = (^d) ^ (PO != 0);
        return f;
    endfunction

    initial forever begin
        int  cnt_pre;
        bit  acc;
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            mq.delete();
            m_left = 0;
            m_bits = '1;
        end else begin
            cyc++;
            cnt_pre = mq.size();
            acc = tx_valid && (cnt_pre != DEPTH);
            if (m_left > 0) m_left--;
            if (m_left == 0 && cnt_pre > 0) begin
                m_bits = frame_of(mq.pop_front());
                m_left = FLC;
            end
            if (acc) mq.push_back(sdata);
        end
    end

    initial forever begin
        logic exp_txd;
        @(negedge clk);
        exp_txd = (m_left > 0) ? m_bits[(FLC - m_left) / BP] : 1'b1;
        check("txd", txd, exp_txd);
        check("fifo_count", fifo_count, mq.size());
        check("tx_ready", tx_ready, mq.size() != DEPTH);
        check("tx_busy", tx_busy, (m_left > 0) || (mq.size() > 0));
    end

    typedef struct {
        logic [8:0]  data;
        logic [15:0] frame;
    } vec_t;

    task automatic push(input logic [DB-1:0] d);
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        sdata = d;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic capture(input logic [15:0] exp_f, input string name);
        logic [15:0] got;
        int unstable;
        got = '0;
        unstable = 0;
        @(negedge clk);
        check({name, " pre-start idle"}, txd, 1'b1);
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < BP; c++) begin
                @(negedge clk);
                if (c == 0) got[i] = txd;
                else if (txd !== got[i]) unstable++;
            end
        end
        check({name, " frame"}, got, exp_f);
        check({name, " bit hold"}, unstable, 0);
        @(negedge clk);
        check({name, " busy drop"}, tx_busy, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int exp_edge);
        bit done;
        done = 1'b0;
        for (int t = 0; t < (DEPTH + 2) * FLC + 20; t++) begin
            @(negedge clk);
            if (!tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, " idle reached"}, done, 1'b1);
        if (exp_edge >= 0) check({name, " drop edge"}, cyc, exp_edge);
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] f55;
        int e;
        int pct;
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{9'h03, 16'h0706};
        vecs[1] = '{9'h7F, 16'h06FE};
        vecs[2] = '{9'h00, 16'h0700};
        vecs[3] = '{9'h55, 16'h07AA};
        vecs[4] = '{9'h01, 16'h0602};
        vecs[5] = '{9'h40, 16'h0680};
        f55 = 16'h07AA;
`else
        vecs[0] = '{9'hA5, 16'h034A};
        vecs[1] = '{9'h00, 16'h0200};
        vecs[2] = '{9'hFF, 16'h03FE};
        vecs[3] = '{9'h3C, 16'h0278};
        vecs[4] = '{9'h01, 16'h0202};
        vecs[5] = '{9'h80, 16'h0300};
        f55 = 16'h02AA;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset txd", txd, 1'b1);
        check("reset count", fifo_count, 0);
        check("reset ready", tx_ready, 1'b1);
        check("reset busy", tx_busy, 1'b0);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            push(DB'(vecs[i].data));
            capture(vecs[i].frame, $sformatf("vec%0d", i));
        end

        @(posedge clk);
        #1;
        e = cyc;
        tx_valid = 1'b1;
        sdata = DB'(9'h000);
        @(posedge clk);
        #1;
        sdata = DB'(9'h0FF);
        @(posedge clk);
        #1;
        sdata = DB'(9'h03C);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        check("burst count", fifo_count, 2);
        wait_idle("burst", e + 2 + 3 * FLC);

        @(posedge clk);
        #1;
        e = cyc;
        for (int k = 0; k < 6; k++) begin
            tx_valid = 1'b1;
            sdata = DB'(k * 7 + 1);
            @(posedge clk);
            #1;
            if (k == 4) begin
                @(negedge clk);
                check("full count", fifo_count, DEPTH);
                check("full ready", tx_ready, 1'b0);
            end
        end
        tx_valid = 1'b0;
        @(negedge clk);
        check("full drop count", fifo_count, DEPTH);
        wait_idle("full", e + 2 + 5 * FLC);

        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        sdata = DB'(9'h05A);
        @(posedge clk);
        #1;
        sdata = DB'(9'h033);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (BP + 3) @(posedge clk);
        #1;
        check("pre-reset txd", txd, 1'b0);
        check("pre-reset count", fifo_count, 1);
        #1;
        rstn = 1'b0;
        #1;
        check("async reset txd", txd, 1'b1);
        check("async reset count", fifo_count, 0);
        check("async reset ready", tx_ready, 1'b1);
        check("async reset busy", tx_busy, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        push(DB'(9'h055));
        capture(f55, "post-reset");

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            pct = (n < 1000) ? 5 : (n < 2000) ? 40 : 90;
            tx_valid = ($urandom_range(0, 99) < pct);
            sdata = DB'($urandom);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_idle("random", -1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
